bcd_stopwatch: RTL
==================

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of 4-bit BCD digits in the count, range 1..8.
REQ-002 Parameter TICK_DIV, default 100000: clk cycles per count increment, range 2..2^24.
REQ-003 Parameter WRAP_MODE, default 1: 1 = wrap to zero after all-9s, 0 = saturate at all-9s.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start_stop  input  1  run/pause request; acts on its rising edge.
REQ-007 clear  input  1  zero request; acts on its rising edge.
REQ-008 lap  input  1  lap freeze/release request; acts on its rising edge.
REQ-009 count  output  4*NUM_DIGITS  live BCD count; digit 0 in bits [3:0] is least significant.
REQ-010 display  output  4*NUM_DIGITS  lap_active ? lap register : count.
REQ-011 running  output  1  high in state RUN.
REQ-012 lap_active  output  1  display frozen.
REQ-013 overflow  output  1  wrap mode: one-cycle pulse; saturate mode: sticky flag.

Function
REQ-014 Edge detection: each control input has a previous-value register; event = input & ~prev; an event acts on the same edge that first samples the input high; holding an input high yields exactly one event.
REQ-015 States: IDLE, RUN, PAUSED.
- IDLE, start_stop -> RUN.
- RUN, start_stop -> PAUSED.
- PAUSED, start_stop -> RUN.
- PAUSED, clear -> IDLE.
REQ-016 clear in RUN zeroes count, prescaler, lap_active and overflow; state stays RUN.
REQ-017 clear in IDLE has no effect beyond keeping everything at zero.
REQ-018 Priority when events coincide: rst > clear > start_stop > lap.
- clear and start_stop in the same cycle: apply clear only; start_stop is dropped.
REQ-019 Prescaler: 0..TICK_DIV-1, advances only in RUN; holds its value in PAUSED (resume keeps the partial period); zero in IDLE.
REQ-020 Tick: occurs on the edge where the prescaler wraps from TICK_DIV-1 to 0; count increments on that same edge.
- The first increment after IDLE->RUN lands TICK_DIV edges after the edge that sampled start_stop.
REQ-021 BCD increment: each digit wraps 9->0 and carries into the next digit; a digit never holds a value above 9.
REQ-022 Wrap mode, tick at all-9s: count becomes 0; overflow is high for exactly the cycle after that edge; state stays RUN.
REQ-023 Saturate mode, tick at all-9s: count holds; overflow sets and stays set until clear or rst; prescaler keeps cycling.
REQ-024 lap event with lap_active=0 in RUN or PAUSED: load the lap register with the current pre-edge count; set lap_active.
REQ-025 lap event with lap_active=1: clear lap_active; display follows count on the next cycle.
REQ-026 lap events in IDLE are ignored.
REQ-027 lap coincident with a tick: the lap register captures the pre-increment value.
REQ-028 Leaving RUN does not affect lap_active; the display stays frozen until a lap event, clear or rst.

Reset
REQ-029 On a clk edge with rst high:
- state IDLE;
- count, lap register and prescaler 0;
- running, lap_active and overflow 0;
- edge-detect registers 0.
REQ-030 rst mid-count or mid-lap aborts immediately with no further increment; rst overrides every coincident event.
REQ-031 After rst deasserts, a control input already held high generates an event on the first sampled edge.

Verification (NUM_DIGITS=2, TICK_DIV=4 unless stated)
REQ-032 start_stop pulse, then 40 cycles -> count steps 00,01,...; 01 appears 4 edges after the start edge and reaches 10 after 40 edges; running=1.
REQ-033 Pause at count 05 with the prescaler at 2, wait 20 cycles, resume -> count stays 05 while paused; 06 appears 2 edges after resume.
REQ-034 WRAP_MODE=1, run from 98 -> 99 then 00, with overflow high for exactly one cycle.
- WRAP_MODE=0 -> holds 99, overflow stays 1 until clear.
REQ-035 lap at count 12, run to 17, lap again -> display holds 12 while count advances, then display=17.
REQ-036 clear and start_stop in the same cycle while PAUSED at 33 -> IDLE, count 00, running 0.
- start_stop held high 10 cycles -> a single transition.
REQ-037 rst asserted in RUN with lap_active=1 -> on the next edge all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// BCD stopwatch: prescaled run/pause counter with lap freeze and wrap or saturate overflow.
// State | meaning: IDLE = stopped and zeroed, RUN = counting, PAUSED = halted with count/prescaler held.
module bcd_stopwatch #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000,
  parameter int WRAP_MODE  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [4*NUM_DIGITS-1:0] display,
  output logic                    running,
  output logic                    lap_active,
  output logic                    overflow
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  function automatic logic [W-1:0] all_nines();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  localparam logic [W-1:0] NINES = all_nines();

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   lap_q, lap_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           lap_active_q, lap_active_d;
  logic           overflow_q, overflow_d;
  logic           ss_prev_q, clr_prev_q, lap_prev_q;
  logic           ss_ev, clr_ev, lap_ev;

  assign ss_ev  = start_stop & ~ss_prev_q;
  assign clr_ev = clear & ~clr_prev_q;
  assign lap_ev = lap & ~lap_prev_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    lap_d        = lap_q;
    presc_d      = presc_q;
    lap_active_d = lap_active_q;
    overflow_d   = (WRAP_MODE != 0) ? 1'b0 : overflow_q;

    if (clr_ev) begin
      count_d      = '0;
      presc_d      = '0;
      lap_active_d = 1'b0;
      overflow_d   = 1'b0;
      if (state_q != RUN) begin
        state_d = IDLE;
        lap_d   = '0;
      end
    end else begin
      if (state_q == RUN) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (count_q == NINES) begin
            overflow_d = 1'b1;
            if (WRAP_MODE != 0) count_d = '0;
          end else begin
            count_d = bcd_inc(count_q);
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      if (ss_ev) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSED;
          PAUSED:  state_d = RUN;
          default: state_d = IDLE;
        endcase
      end

      // lap captures the pre-edge count, so a coincident tick is not seen
      if (lap_ev && state_q != IDLE) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else begin
          lap_d        = count_q;
          lap_active_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      lap_q        <= '0;
      presc_q      <= '0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
      ss_prev_q    <= 1'b0;
      clr_prev_q   <= 1'b0;
      lap_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      lap_q        <= lap_d;
      presc_q      <= presc_d;
      lap_active_q <= lap_active_d;
      overflow_q   <= overflow_d;
      ss_prev_q    <= start_stop;
      clr_prev_q   <= clear;
      lap_prev_q   <= lap;
    end
  end

  assign count      = count_q;
  assign display    = lap_active_q ? lap_q : count_q;
  assign running    = (state_q == RUN);
  assign lap_active = lap_active_q;
  assign overflow   = overflow_q;

endmodule
